vc_port_requester: RTL

//  Requester end of the router output-arbitration protocol. Buffers incoming flits per virtual channel (VC0/VC1).
//  XY-routes each VC head and drives one request line toward the 4-input round-robin arbiter of the selected output.

---
 rtl/vc_port_requester_pkg.sv | 49 ++++
 rtl/vc_port_requester_fifo.sv | 72 +++++++
 rtl/vc_port_requester.sv | 86 ++++++++
 3 files changed

// File: rtl/vc_port_requester_pkg.sv
// Shared NoC definitions: flit field offsets, output-port indices
// and the XY routing function used by every requester.
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int COORD_W   = 2;

  localparam int PORT_E  = 0;
  localparam int PORT_W  = 1;
  localparam int PORT_S  = 2;
  localparam int PORT_N  = 3;
  localparam int PORT_PE = 4;

  localparam int DST_X_LSB = 48;
  localparam int DST_Y_LSB = 50;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [NUM_PORTS-1:0] port_vec_t;

  // The VC id always sits in the flit MSB.
  function automatic int vc_bit(input int pkt_w);
    return pkt_w - 1;
  endfunction

  // X first, then Y; equal coordinates eject to the local PE.
  function automatic port_vec_t route_xy(
    input coord_t dx,
    input coord_t dy,
    input coord_t mx,
    input coord_t my
  );
    port_vec_t r;
    r = '0;
    unique case (1'b1)
      (dx > mx):
        r[PORT_E] = 1'b1;
      (dx < mx):
        r[PORT_W] = 1'b1;
      (dx == mx) && (dy > my):
        r[PORT_S] = 1'b1;
      (dx == mx) && (dy < my):
        r[PORT_N] = 1'b1;
      default:
        r[PORT_PE] = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vc_port_requester_fifo.sv
// Per-VC flit FIFO with registered occupancy.
// Full/empty come from the count register only, never from this cycle's pop.
module vc_fifo
  import noc_pkg::*;
#(
  parameter int PKT_W = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [PKT_W-1:0] data_i,
  output logic [PKT_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth: pointer wrap is plain overflow.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      wr_d = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/vc_port_requester.sv
// Router input-port requester: two VC FIFOs, XY route, one-hot request.
// Define GNT_CHECK_EN to build the sticky grant-protocol error flag.
module vc_port_requester
  import noc_pkg::*;
#(
  parameter int PKT_W = 64,
  parameter int DEPTH = 2,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 polarity,
  input  logic                 in_valid,
  input  logic [PKT_W-1:0]     in_data,
  output logic [1:0]           in_ready,
  output logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] gnt,
  output logic [PKT_W-1:0]     out_data,
  output logic                 err
);

  localparam int VC_BIT = vc_bit(PKT_W);

  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [PKT_W-1:0] head [2];
  logic             granted;
  port_vec_t        route;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    assign push[v] = in_valid & (in_data[VC_BIT] == 1'(v));
    assign pop[v]  = granted & (polarity == 1'(v));

    vc_fifo #(
      .PKT_W (PKT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push[v]),
      .pop_i   (pop[v]),
      .data_i  (in_data),
      .head_o  (head[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  assign in_ready = ~full;
  assign out_data = head[polarity];

  assign route = route_xy(
    out_data[DST_X_LSB +: COORD_W],
    out_data[DST_Y_LSB +: COORD_W],
    coord_t'(MY_X),
    coord_t'(MY_Y)
  );

  // Empty count clears asynchronously, so req drops with reset.
  assign req     = empty[polarity] ? '0 : route;
  assign granted = |(gnt & req);

`ifdef GNT_CHECK_EN
  logic err_q;
  logic gnt_bad;

  assign gnt_bad = (|(gnt & ~req)) |
                   (|(gnt & (gnt - NUM_PORTS'(1))));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (gnt_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
